dm_dac_frame_scheduler: RTL and testbench

- Sequences DAC word transfers for the six deformable-mirror SPI channels (A-F) onto one shared SPI shift engine. The engine drives the common SckADCs and the per-channel nCs/Mosi lines.
- Sits between the APB-fed register file in DMMainPorts and the SPI engine.
- Per-channel holding registers feed a round-robin arbiter. After each frame drains, a commit generates the nLDacs load pulse.

---
 rtl/dm_dac_frame_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_dm_dac_frame_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_dac_frame_scheduler.sv
// dm_dac_frame_scheduler
//
// Sequences DAC word transfers for the six deformable-mirror SPI channels
// onto one shared SPI shift engine. Each channel has a holding register and a
// pending flag; a round-robin arbiter picks the next pending channel whenever
// the engine is free. Once all pending words have been sent, a latched commit
// produces one active-low nLDac load pulse.
//
// Ports:
//   clk          system clock
//   nRst         asynchronous active-low reset
//   WrStrobe     one-cycle write of WrData into holding register WrChan
//   WrChan       target channel (values >= NUM_CH ignored)
//   WrData       DAC word
//   Commit       one-cycle request for an nLDac pulse after pending words drain
//   PPS          pulse-per-second, only used when DM_SCHED_PPS_COMMIT_EN is defined
//   XferStart    one-cycle start pulse to the SPI engine
//   XferChan     channel of the current transfer, held until the next grant
//   XferData     word of the current transfer, held until the next grant
//   XferDone     one-cycle completion pulse from the SPI engine
//   nLDac        DAC load strobe, active low
//   Pending      per-channel pending flags
//   Busy         high in every state except IDLE
//   Overwrites   saturating count of overwrites of a not-yet-sent word
//   TimeoutErr   sticky, set when XferDone does not arrive in time
//
// Build option: define DM_SCHED_PPS_COMMIT_EN to let rising edges of PPS act
// as commits (2-flop synchronizer plus edge detector).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | engine free; grant next pending channel, else start a commit
// WAIT  | transfer in flight; wait for XferDone or the timeout
// LDAC  | nLDac held low for LDAC_CYCLES cycles

module dm_dac_frame_scheduler #(
  parameter int NUM_CH         = 6,
  parameter int DATA_W         = 24,
  parameter int LDAC_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              WrStrobe,
  input  logic [2:0]        WrChan,
  input  logic [DATA_W-1:0] WrData,
  input  logic              Commit,
  input  logic              PPS,
  output logic              XferStart,
  output logic [2:0]        XferChan,
  output logic [DATA_W-1:0] XferData,
  input  logic              XferDone,
  output logic              nLDac,
  output logic [NUM_CH-1:0] Pending,
  output logic              Busy,
  output logic [7:0]        Overwrites,
  output logic              TimeoutErr
);

  localparam int CH_W  = 3;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_LDAC = 2'd2;

  localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] LDAC_LOAD = TMR_W'(LDAC_CYCLES - 1);

  logic [1:0]        state_q,       state_d;
  logic [TMR_W-1:0]  timer_q,       timer_d;
  logic [CH_W-1:0]   last_q,        last_d;
  logic [NUM_CH-1:0] pending_q,     pending_d;
  logic [DATA_W-1:0] hold_q [NUM_CH];
  logic [DATA_W-1:0] hold_d [NUM_CH];
  logic              commit_q,      commit_d;
  logic              xfer_start_q,  xfer_start_d;
  logic [CH_W-1:0]   xfer_chan_q,   xfer_chan_d;
  logic [DATA_W-1:0] xfer_data_q,   xfer_data_d;
  logic              nldac_q,       nldac_d;
  logic [7:0]        ovw_q,         ovw_d;
  logic              timeout_err_q, timeout_err_d;

  logic              pps_commit;
  logic              commit_req;
  logic              wr_valid;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_taken;

`ifdef DM_SCHED_PPS_COMMIT_EN
  logic pps_meta_q, pps_sync_q, pps_prev_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pps_meta_q <= 1'b0;
      pps_sync_q <= 1'b0;
      pps_prev_q <= 1'b0;
    end else begin
      pps_meta_q <= PPS;
      pps_sync_q <= pps_meta_q;
      pps_prev_q <= pps_sync_q;
    end
  end

  assign pps_commit = pps_sync_q & ~pps_prev_q;
`else
  logic unused_pps;
  assign unused_pps = PPS;
  assign pps_commit = 1'b0;
`endif

  // A Commit and a PPS edge in the same cycle collapse into one request.
  assign commit_req = Commit | pps_commit;
  assign wr_valid   = WrStrobe && (WrChan < CH_W'(NUM_CH));

  // Round-robin search starting at last+1; scanning from the far end down
  // lets the nearest pending channel overwrite any farther candidate.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (pending_q[CH_W'((int'(last_q) + i) % NUM_CH)]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'((int'(last_q) + i) % NUM_CH);
      end
    end
  end

  assign grant_taken = (state_q == ST_IDLE) && grant_vld;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    last_d        = last_q;
    pending_d     = pending_q;
    hold_d        = hold_q;
    commit_d      = commit_q | commit_req;
    xfer_start_d  = 1'b0;
    xfer_chan_d   = xfer_chan_q;
    xfer_data_d   = xfer_data_q;
    nldac_d       = nldac_q;
    ovw_d         = ovw_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          xfer_start_d         = 1'b1;
          xfer_chan_d          = grant_idx;
          xfer_data_d          = hold_q[grant_idx];
          pending_d[grant_idx] = 1'b0;
          last_d               = grant_idx;
          timer_d              = TMO_LOAD;
          state_d              = ST_WAIT;
        end else if (commit_q) begin
          // A commit arriving on this very edge belongs to the next pulse.
          nldac_d  = 1'b0;
          commit_d = commit_req;
          timer_d  = LDAC_LOAD;
          state_d  = ST_LDAC;
        end
      end
      ST_WAIT: begin
        if (XferDone) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_LDAC: begin
        if (timer_q == '0) begin
          nldac_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the grant so a write to the channel being granted wins:
    // the old word goes out, the new one stays pending. That case is not an
    // overwrite because the old word was not lost.
    if (wr_valid) begin
      if (pending_q[WrChan] && !(grant_taken && (grant_idx == WrChan)) &&
          (ovw_q != 8'hFF)) begin
        ovw_d = ovw_q + 8'd1;
      end
      pending_d[WrChan] = 1'b1;
      hold_d[WrChan]    = WrData;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      last_q        <= CH_W'(NUM_CH - 1);
      pending_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
      commit_q      <= 1'b0;
      xfer_start_q  <= 1'b0;
      xfer_chan_q   <= '0;
      xfer_data_q   <= '0;
      nldac_q       <= 1'b1;
      ovw_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      last_q        <= last_d;
      pending_q     <= pending_d;
      hold_q        <= hold_d;
      commit_q      <= commit_d;
      xfer_start_q  <= xfer_start_d;
      xfer_chan_q   <= xfer_chan_d;
      xfer_data_q   <= xfer_data_d;
      nldac_q       <= nldac_d;
      ovw_q         <= ovw_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign XferStart  = xfer_start_q;
  assign XferChan   = xfer_chan_q;
  assign XferData   = xfer_data_q;
  assign nLDac      = nldac_q;
  assign Pending    = pending_q;
  assign Busy       = (state_q != ST_IDLE);
  assign Overwrites = ovw_q;
  assign TimeoutErr = timeout_err_q;

endmodule

// File: tb/tb_dm_dac_frame_scheduler.sv
module tb_dm_dac_frame_scheduler;

  logic        clk = 1'b0;
  logic        nRst;
  logic        wr_strobe;
  logic [2:0]  wr_chan;
  logic [23:0] wr_data;
  logic        commit;
  logic        pps;
  logic        done_man;
  logic        done_auto;
  logic        xfer_done;
  logic        XferStart;
  logic [2:0]  XferChan;
  logic [23:0] XferData;
  logic        nLDac;
  logic [5:0]  Pending;
  logic        Busy;
  logic [7:0]  Overwrites;
  logic        TimeoutErr;

  assign xfer_done = done_man | done_auto;

  always #5 clk = ~clk;

  dm_dac_frame_scheduler dut (
    .clk        (clk),
    .nRst       (nRst),
    .WrStrobe   (wr_strobe),
    .WrChan     (wr_chan),
    .WrData     (wr_data),
    .Commit     (commit),
    .PPS        (pps),
    .XferStart  (XferStart),
    .XferChan   (XferChan),
    .XferData   (XferData),
    .XferDone   (xfer_done),
    .nLDac      (nLDac),
    .Pending    (Pending),
    .Busy       (Busy),
    .Overwrites (Overwrites),
    .TimeoutErr (TimeoutErr)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  ch;
    logic [23:0] data;
    logic        commit;
    logic        done;
    logic        e_start;
    logic [2:0]  e_chan;
    logic [23:0] e_data;
    logic        e_nldac;
    logic [5:0]  e_pend;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  // Monitor: log every transfer start and track nLDac pulses.
  logic [2:0]  log_chan[$];
  logic [23:0] log_data[$];
  int   ldac_low = 0;
  int   pulses = 0;
  int   starts_at_pulse = 0;
  logic nldac_prev = 1'b1;

  always @(negedge clk) begin
    if (XferStart) begin
      log_chan.push_back(XferChan);
      log_data.push_back(XferData);
    end
    if (!nLDac) ldac_low <= ldac_low + 1;
    if (nldac_prev && !nLDac) begin
      pulses <= pulses + 1;
      starts_at_pulse <= log_chan.size();
    end
    nldac_prev <= nLDac;
  end

  // Automatic SPI engine model: answers each start after done_dly cycles.
  logic auto_en = 1'b0;
  int   done_dly = 3;

  initial begin
    done_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_en && XferStart) begin
        repeat (done_dly) @(negedge clk);
        done_auto = 1'b1;
        @(negedge clk);
        done_auto = 1'b0;
      end
    end
  end

  function automatic void add_vec(input logic wr, input logic [2:0] ch,
                                  input logic [23:0] data, input logic cm,
                                  input logic dn, input logic e_start,
                                  input logic [2:0] e_chan, input logic [23:0] e_data,
                                  input logic e_nldac, input logic [5:0] e_pend,
                                  input logic e_busy);
    vec_t v;
    v.wr = wr; v.ch = ch; v.data = data; v.commit = cm; v.done = dn;
    v.e_start = e_start; v.e_chan = e_chan; v.e_data = e_data;
    v.e_nldac = e_nldac; v.e_pend = e_pend; v.e_busy = e_busy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [2:0] ch,
                         input logic [23:0] d);
    if (idx >= log_chan.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: transfer %0d missing, only %0d logged", name, idx, log_chan.size());
    end else begin
      chk(name, 64'({log_chan[idx], log_data[idx]}), 64'({ch, d}));
    end
  endtask

  task automatic expect_start(input string name, input logic [2:0] ch, input logic [23:0] d);
    int n;
    @(negedge clk);
    n = 1;
    while (!XferStart && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!XferStart) begin
      checks++;
      errors++;
      $display("FAIL %s: no XferStart within 30 cycles", name);
    end else begin
      chk(name, 64'({XferChan, XferData}), 64'({ch, d}));
    end
  endtask

  task automatic drive_wr(input logic [2:0] ch, input logic [23:0] d);
    wr_strobe = 1'b1;
    wr_chan   = ch;
    wr_data   = d;
  endtask

  task automatic check_reset_outs(input string name);
    chk(name, 64'({XferStart, XferChan, XferData, nLDac, Pending, Busy, Overwrites, TimeoutErr}),
        64'({1'b0, 3'd0, 24'd0, 1'b1, 6'd0, 1'b0, 8'd0, 1'b0}));
  endtask

  initial begin
    int base;
    int pbase;
    int lbase;
    int cnt;

    nRst = 1'b0; wr_strobe = 1'b0; wr_chan = '0; wr_data = '0;
    commit = 1'b0; pps = 1'b0; done_man = 1'b0;

    // Single transfer, out-of-range write, stray XferDone, one commit pulse.
    add_vec(1, 3'd2, 24'h123456, 0, 0,  0, 3'd0, 24'h000000, 1, 6'b000100, 0);
    add_vec(0, 3'd0, 24'h0,      0, 0,  1, 3'd2, 24'h123456, 1, 6'b000000, 1);
    for (int i = 0; i < 9; i++)
      add_vec(0, 3'd0, 24'h0,    0, 0,  0, 3'd2, 24'h123456, 1, 6'b000000, 1);
    add_vec(0, 3'd0, 24'h0,      0, 1,  0, 3'd2, 24'h123456, 1, 6'b000000, 0);
    add_vec(0, 3'd0, 24'h0,      0, 0,  0, 3'd2, 24'h123456, 1, 6'b000000, 0);
    add_vec(1, 3'd7, 24'hFFFFFF, 0, 0,  0, 3'd2, 24'h123456, 1, 6'b000000, 0);
    add_vec(0, 3'd0, 24'h0,      0, 1,  0, 3'd2, 24'h123456, 1, 6'b000000, 0);
    add_vec(0, 3'd0, 24'h0,      1, 0,  0, 3'd2, 24'h123456, 1, 6'b000000, 0);
    for (int i = 0; i < 4; i++)
      add_vec(0, 3'd0, 24'h0,    0, 0,  0, 3'd2, 24'h123456, 0, 6'b000000, 1);
    add_vec(0, 3'd0, 24'h0,      0, 0,  0, 3'd2, 24'h123456, 1, 6'b000000, 0);
    add_vec(0, 3'd0, 24'h0,      0, 0,  0, 3'd2, 24'h123456, 1, 6'b000000, 0);

    repeat (3) @(negedge clk);
    check_reset_outs("reset_values");
    nRst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr_strobe = vecs[i].wr;
      wr_chan   = vecs[i].ch;
      wr_data   = vecs[i].data;
      commit    = vecs[i].commit;
      done_man  = vecs[i].done;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          64'({XferStart, XferChan, XferData, nLDac, Pending, Busy}),
          64'({vecs[i].e_start, vecs[i].e_chan, vecs[i].e_data, vecs[i].e_nldac,
               vecs[i].e_pend, vecs[i].e_busy}));
    end
    @(negedge clk);
    wr_strobe = 1'b0; commit = 1'b0; done_man = 1'b0;
    chk("table_overwrites", 64'(Overwrites), 64'd0);

    // Three channels then a commit: order 0,3,5 and one 4-cycle pulse after.
    auto_en = 1'b1; done_dly = 3;
    base = log_chan.size(); pbase = pulses; lbase = ldac_low;
    @(negedge clk); drive_wr(3'd0, 24'h000001);
    @(negedge clk); drive_wr(3'd3, 24'h000003);
    @(negedge clk); drive_wr(3'd5, 24'h000005);
    @(negedge clk); wr_strobe = 1'b0; commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    repeat (100) @(negedge clk);
    chk_log("order_first",  base,     3'd0, 24'h000001);
    chk_log("order_second", base + 1, 3'd3, 24'h000003);
    chk_log("order_third",  base + 2, 3'd5, 24'h000005);
    chk("order_count", 64'(log_chan.size() - base), 64'd3);
    chk("commit_pulses", 64'(pulses - pbase), 64'd1);
    chk("commit_low_cycles", 64'(ldac_low - lbase), 64'd4);
    chk("pulse_after_all_xfers", 64'(starts_at_pulse - base), 64'd3);

    // Round robin: ch3 served last, then ch1 and ch4 pending -> ch4 first.
    done_dly = 10;
    base = log_chan.size();
    @(negedge clk); drive_wr(3'd3, 24'h333333);
    @(negedge clk); wr_strobe = 1'b0;
    @(negedge clk); drive_wr(3'd1, 24'h111111);
    @(negedge clk); drive_wr(3'd4, 24'h444444);
    @(negedge clk); wr_strobe = 1'b0;
    repeat (80) @(negedge clk);
    chk_log("rr_first",  base,     3'd3, 24'h333333);
    chk_log("rr_second", base + 1, 3'd4, 24'h444444);
    chk_log("rr_third",  base + 2, 3'd1, 24'h111111);

    // Overwrite of ch1 while the engine is busy on ch0.
    base = log_chan.size();
    @(negedge clk); drive_wr(3'd0, 24'h000ABC);
    @(negedge clk); wr_strobe = 1'b0;
    @(negedge clk); drive_wr(3'd1, 24'hAAAAAA);
    @(negedge clk); drive_wr(3'd1, 24'h555555);
    @(negedge clk); wr_strobe = 1'b0;
    repeat (60) @(negedge clk);
    chk("overwrite_count", 64'(Overwrites), 64'd1);
    chk_log("ovw_first",  base,     3'd0, 24'h000ABC);
    chk_log("ovw_second", base + 1, 3'd1, 24'h555555);
    chk("ovw_sent_once", 64'(log_chan.size() - base), 64'd2);

    // Write to ch1 on the same edge it is granted.
    auto_en = 1'b0;
    @(negedge clk); drive_wr(3'd2, 24'h0F0F0F);
    @(negedge clk); drive_wr(3'd1, 24'h111111);
    @(negedge clk); wr_strobe = 1'b0;
    @(negedge clk); done_man = 1'b1;
    @(negedge clk); done_man = 1'b0; drive_wr(3'd1, 24'h222222);
    @(negedge clk); wr_strobe = 1'b0;
    chk("same_edge_grant", 64'({XferStart, XferChan, XferData}), 64'({1'b1, 3'd1, 24'h111111}));
    chk("same_edge_pending", 64'(Pending), 64'(6'b000010));
    chk("same_edge_overwrites", 64'(Overwrites), 64'd1);
    @(negedge clk); done_man = 1'b1;
    @(negedge clk); done_man = 1'b0;
    expect_start("same_edge_reissue", 3'd1, 24'h222222);
    @(negedge clk); done_man = 1'b1;
    @(negedge clk); done_man = 1'b0;

    // Timeout: ch4 never completes, ch5 follows.
    @(negedge clk); drive_wr(3'd4, 24'h444444);
    @(negedge clk); drive_wr(3'd5, 24'h555555);
    @(negedge clk); wr_strobe = 1'b0;
    chk("timeout_start", 64'({XferStart, XferChan}), 64'({1'b1, 3'd4}));
    cnt = 0;
    while (!TimeoutErr && cnt < 1100) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_latency", 64'(cnt), 64'd1024);
    chk("timeout_idle", 64'(Busy), 64'd0);
    @(negedge clk);
    chk("timeout_next", 64'({XferStart, XferChan, XferData}), 64'({1'b1, 3'd5, 24'h555555}));
    done_man = 1'b1;
    @(negedge clk); done_man = 1'b0;

    // Reset in the middle of a transfer.
    @(negedge clk); drive_wr(3'd0, 24'hABCDEF);
    @(negedge clk); wr_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_xfer_busy", 64'(Busy), 64'd1);
    nRst = 1'b0;
    #1;
    check_reset_outs("mid_xfer_reset");
    repeat (2) @(negedge clk);
    nRst = 1'b1;

    // Two commits while busy merge into one pulse.
    auto_en = 1'b1; done_dly = 8;
    pbase = pulses; lbase = ldac_low;
    @(negedge clk); drive_wr(3'd3, 24'h303030);
    @(negedge clk); wr_strobe = 1'b0;
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    repeat (40) @(negedge clk);
    chk("merge_pulses", 64'(pulses - pbase), 64'd1);
    chk("merge_low_cycles", 64'(ldac_low - lbase), 64'd4);

    // Commit during LDAC gives a second pulse.
    auto_en = 1'b0;
    pbase = pulses; lbase = ldac_low;
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    @(negedge clk);
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    repeat (20) @(negedge clk);
    chk("ldac_commit_pulses", 64'(pulses - pbase), 64'd2);
    chk("ldac_commit_low_cycles", 64'(ldac_low - lbase), 64'd8);

`ifdef DM_SCHED_PPS_COMMIT_EN
    pbase = pulses;
    @(negedge clk); pps = 1'b1;
    cnt = 0;
    while (nLDac && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("pps_latency_3_to_4", 64'((cnt >= 3) && (cnt <= 4)), 64'd1);
    repeat (10) @(negedge clk);
    pps = 1'b0;
    repeat (10) @(negedge clk);
    chk("pps_pulses", 64'(pulses - pbase), 64'd1);
`else
    pbase = pulses;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); pps = ~pps;
      repeat (6) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("pps_ignored_pulses", 64'(pulses - pbase), 64'd0);
    chk("pps_ignored_nldac", 64'(nLDac), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
